ttl_74112_sync_bank: RTL and testbench



---
 rtl/ttl_74112_sync_bank_pkg.sv | 29 ++
 rtl/ttl_74112_sync_bank_if.sv | 25 ++
 rtl/ttl_cen_edge_det.sv | 42 ++++
 rtl/ttl_74112_sync_bank.sv | 79 +++++++
 tb/tb_ttl_74112_sync_bank.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/ttl_74112_sync_bank_pkg.sv
// Shared definitions for the synchronous 74-series flip-flop models:
// trigger polarity encodings, JK command encodings and the JK next-state function.
package ttl_sync_pkg;

  localparam logic EDGE_FALL = 1'b0;
  localparam logic EDGE_RISE = 1'b1;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_cmd_t;

  function automatic logic jk_next(input logic j, input logic k, input logic q);
    jk_cmd_t cmd;
    logic    nxt;
    cmd = jk_cmd_t'({j, k});
    case (cmd)
      JK_HOLD:   nxt = q;
      JK_RESET:  nxt = 1'b0;
      JK_SET:    nxt = 1'b1;
      JK_TOGGLE: nxt = ~q;
      default:   nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ttl_74112_sync_bank_if.sv
// Signal bundle of the JK flip-flop bank: emulated TTL nets in, flip-flop outputs back.
interface ttl_74112_sync_bank_if #(
  parameter int BLOCKS = 4
);

  logic [BLOCKS-1:0] Cen;
  logic [BLOCKS-1:0] PREn;
  logic [BLOCKS-1:0] CLRn;
  logic [BLOCKS-1:0] J;
  logic [BLOCKS-1:0] K;
  logic [BLOCKS-1:0] Q;
  logic [BLOCKS-1:0] Qn;
  logic [BLOCKS-1:0] Trig;

  modport master (
    output Cen, PREn, CLRn, J, K,
    input  Q, Qn, Trig
  );

  modport slave (
    input  Cen, PREn, CLRn, J, K,
    output Q, Qn, Trig
  );

endinterface

// File: rtl/ttl_cen_edge_det.sv
// Edge detector for an emulated TTL clock net sampled by the system clock.
// fire is combinational for the same-cycle state update; trig is its registered copy.
module ttl_cen_edge_det
  import ttl_sync_pkg::*;
#(
  parameter logic POLARITY = EDGE_FALL
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic src,
  output logic fire,
  output logic trig
);

  logic r_last;
  logic r_trig;
  logic w_fire;

  // Compare the current source level against the previous one for the active edge
  always_comb begin
    if (POLARITY == EDGE_RISE) begin
      w_fire = ~r_last & src;
    end else begin
      w_fire = r_last & ~src;
    end
  end

  // History resets to the non-triggering level so release never fires spuriously
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_last <= POLARITY;
      r_trig <= 1'b0;
    end else begin
      r_last <= src;
      r_trig <= w_fire;
    end
  end

  assign fire = w_fire;
  assign trig = r_trig;

endmodule

// File: rtl/ttl_74112_sync_bank.sv
// Bank of synchronous-emulation 74LS112-style JK flip-flops with per-channel
// preset/clear, trigger polarity and optional ripple cascading from the previous channel.
module ttl_74112_sync_bank #(
  parameter int              BLOCKS    = 4,
  parameter logic [BLOCKS-1:0] EDGE_RISE = {BLOCKS{1'b0}},
  parameter logic [BLOCKS-1:0] CASCADE   = {BLOCKS{1'b0}},
  parameter logic [BLOCKS-1:0] INIT_Q    = {BLOCKS{1'b0}}
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  ttl_74112_sync_bank_if.slave  bus
);

  import ttl_sync_pkg::*;

  logic [BLOCKS-1:0] w_src;
  logic [BLOCKS-1:0] w_fire;
  logic [BLOCKS-1:0] w_trig;
  logic [BLOCKS-1:0] w_q_nxt;
  logic [BLOCKS-1:0] w_both;
  logic [BLOCKS-1:0] r_q;
  logic [BLOCKS-1:0] r_q_o;
  logic [BLOCKS-1:0] r_qn_o;

  for (genvar g = 0; g < BLOCKS; g++) begin : g_ch
    // Cascaded channels take the stored Q of the previous stage, adding one Clk per stage
    if ((g > 0) && CASCADE[g]) begin : g_casc
      assign w_src[g] = r_q[g-1];
    end else begin : g_cen
      assign w_src[g] = bus.Cen[g];
    end

    ttl_cen_edge_det #(
      .POLARITY (EDGE_RISE[g])
    ) u_edge (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .src     (w_src[g]),
      .fire    (w_fire[g]),
      .trig    (w_trig[g])
    );
  end

  // Next stored state: clear, then preset, then JK on a fire; an overridden fire is dropped
  always_comb begin
    w_q_nxt = r_q;
    w_both  = {BLOCKS{1'b0}};
    for (int i = 0; i < BLOCKS; i++) begin
      w_both[i] = ~bus.CLRn[i] & ~bus.PREn[i];
      if (!bus.CLRn[i]) begin
        w_q_nxt[i] = 1'b0;
      end else if (!bus.PREn[i]) begin
        w_q_nxt[i] = 1'b1;
      end else if (w_fire[i]) begin
        w_q_nxt[i] = jk_next(bus.J[i], bus.K[i], r_q[i]);
      end else begin
        w_q_nxt[i] = r_q[i];
      end
    end
  end

  // Stored state plus registered outputs; both-asserted drives Q and Qn high like the 74112
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_q    <= INIT_Q;
      r_q_o  <= INIT_Q;
      r_qn_o <= ~INIT_Q;
    end else begin
      r_q    <= w_q_nxt;
      r_q_o  <= w_q_nxt | w_both;
      r_qn_o <= ~w_q_nxt | w_both;
    end
  end

  assign bus.Q    = r_q_o;
  assign bus.Qn   = r_qn_o;
  assign bus.Trig = w_trig;

endmodule

// File: tb/tb_ttl_74112_sync_bank.sv
// Scoreboard bench for ttl_74112_sync_bank: two configurations (independent and ripple-cascaded),
// directed stimulus queues hand-computed expectations, a negedge monitor compares them.
module tb_ttl_74112_sync_bank;

  typedef struct {
    int         cyc;
    bit         dut;
    logic [3:0] q;
    logic [3:0] qn;
    logic [3:0] tr;
    string      nm;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   errors;
  int   checks;
  bit   draining;
  exp_t sb[$];
  exp_t keep[$];

  ttl_74112_sync_bank_if #(.BLOCKS(4)) ifa ();
  ttl_74112_sync_bank_if #(.BLOCKS(4)) ifb ();

  ttl_74112_sync_bank #(
    .BLOCKS    (4),
    .EDGE_RISE (4'b0010),
    .CASCADE   (4'b0000),
    .INIT_Q    (4'b0101)
  ) dut_a (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (ifa)
  );

  ttl_74112_sync_bank #(
    .BLOCKS    (4),
    .EDGE_RISE (4'b0000),
    .CASCADE   (4'b1110),
    .INIT_Q    (4'b0000)
  ) dut_b (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input bit d, input int dly, input logic [3:0] q, input logic [3:0] qn,
                    input logic [3:0] tr, input string nm);
    exp_t e;
    e.cyc = cyc + dly;
    e.dut = d;
    e.q   = q;
    e.qn  = qn;
    e.tr  = tr;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  // Monitor: compare every entry due this cycle; anything overdue or left at drain time fails
  initial begin
    errors = 0;
    checks = 0;
    forever begin
      @(negedge clk);
      keep = {};
      foreach (sb[i]) begin
        if (sb[i].cyc == cyc) begin
          logic [11:0] got;
          got = sb[i].dut ? {ifb.Q, ifb.Qn, ifb.Trig} : {ifa.Q, ifa.Qn, ifa.Trig};
          checks++;
          if (got !== {sb[i].q, sb[i].qn, sb[i].tr}) begin
            errors++;
            $display("FAIL %s (cyc %0d): got Q=%b Qn=%b Trig=%b, expected Q=%b Qn=%b Trig=%b",
                     sb[i].nm, cyc, got[11:8], got[7:4], got[3:0], sb[i].q, sb[i].qn, sb[i].tr);
          end
        end else if (sb[i].cyc < cyc || draining) begin
          checks++;
          errors++;
          $display("FAIL %s: no sample taken at cyc %0d (now %0d)", sb[i].nm, sb[i].cyc, cyc);
        end else begin
          keep.push_back(sb[i]);
        end
      end
      sb = keep;
    end
  end

  initial begin
    logic [3:0] eq;
    logic [3:0] et;
    logic [3:0] prev;
    logic [3:0] cur;
    logic [3:0] mask;
    draining = 1'b0;
    rst_n    = 1'b0;
    ifa.Cen = 4'b0000; ifa.PREn = 4'b1111; ifa.CLRn = 4'b1111; ifa.J = 4'b0000; ifa.K = 4'b0000;
    ifb.Cen = 4'b0000; ifb.PREn = 4'b1111; ifb.CLRn = 4'b1111; ifb.J = 4'b0000; ifb.K = 4'b0000;

    step();
    ex(1'b0, 0, 4'b0101, 4'b1010, 4'b0000, "rst_a");
    ex(1'b1, 0, 4'b0000, 4'b1111, 4'b0000, "rst_b");
    step();
    step();
    rst_n = 1'b1;
    ex(1'b0, 1, 4'b0101, 4'b1010, 4'b0000, "first_after_release");
    step();

    // Channel 0 toggles on each falling edge of an 8-Clk square wave
    ifa.J[0] = 1'b1;
    ifa.K[0] = 1'b1;
    for (int p = 0; p < 4; p++) begin
      ifa.Cen[0] = 1'b1;
      eq = {3'b010, ~p[0]};
      ex(1'b0, 1, eq, ~eq, 4'b0000, "toggle_rise_no_trig");
      repeat (4) step();
      ifa.Cen[0] = 1'b0;
      eq = {3'b010, p[0]};
      ex(1'b0, 1, eq, ~eq, 4'b0001, "toggle_fall");
      ex(1'b0, 2, eq, ~eq, 4'b0000, "toggle_trig_one_cycle");
      repeat (4) step();
    end

    // Channel 1 is rising-edge triggered, JK=10
    ifa.J[1] = 1'b1;
    ifa.K[1] = 1'b0;
    ifa.Cen[1] = 1'b1;
    ex(1'b0, 1, 4'b0111, 4'b1000, 4'b0010, "rise_fire");
    ex(1'b0, 2, 4'b0111, 4'b1000, 4'b0000, "rise_after");
    repeat (3) step();
    ifa.Cen[1] = 1'b0;
    ex(1'b0, 1, 4'b0111, 4'b1000, 4'b0000, "rise_fall_ignored");
    step();
    step();

    // Channel 2: preset overrides a coincident JK=01 fire, then clear+preset together
    ifa.J[2] = 1'b0;
    ifa.K[2] = 1'b1;
    ifa.Cen[2] = 1'b1;
    step();
    step();
    ifa.Cen[2] = 1'b0;
    ifa.PREn[2] = 1'b0;
    ex(1'b0, 1, 4'b0111, 4'b1000, 4'b0100, "preset_over_fire");
    step();
    ifa.PREn[2] = 1'b1;
    ex(1'b0, 1, 4'b0111, 4'b1000, 4'b0000, "preset_release");
    step();
    ifa.CLRn[2] = 1'b0;
    ifa.PREn[2] = 1'b0;
    ex(1'b0, 1, 4'b0111, 4'b1100, 4'b0000, "both_low");
    step();
    ex(1'b0, 1, 4'b0111, 4'b1100, 4'b0000, "both_low_hold");
    step();
    ifa.CLRn[2] = 1'b1;
    ifa.PREn[2] = 1'b1;
    ex(1'b0, 1, 4'b0011, 4'b1100, 4'b0000, "both_release");
    step();

    // Channel 3: a Cen pulse exactly one Clk wide
    ifa.J[3] = 1'b1;
    ifa.K[3] = 1'b1;
    ifa.Cen[3] = 1'b1;
    ex(1'b0, 1, 4'b0011, 4'b1100, 4'b0000, "narrow_rise");
    step();
    ifa.Cen[3] = 1'b0;
    ex(1'b0, 1, 4'b1011, 4'b0100, 4'b1000, "narrow_fall");
    ex(1'b0, 2, 4'b1011, 4'b0100, 4'b0000, "narrow_single");
    repeat (3) step();

    // Reset asserted mid-run while Cen[0] toggles
    for (int t = 0; t < 3; t++) begin
      ifa.Cen[0] = ~ifa.Cen[0];
      step();
    end
    rst_n = 1'b0;
    ifa.Cen = 4'b0000;
    ex(1'b0, 0, 4'b0101, 4'b1010, 4'b0000, "midrun_reset_a");
    ex(1'b1, 0, 4'b0000, 4'b1111, 4'b0000, "midrun_reset_b");
    step();
    rst_n = 1'b1;
    ex(1'b0, 1, 4'b0101, 4'b1010, 4'b0000, "midrun_release");
    step();
    step();

    // Ripple counter: each stage settles one Clk after the one below it
    ifb.J = 4'b1111;
    ifb.K = 4'b1111;
    for (int n = 1; n <= 16; n++) begin
      ifb.Cen[0] = 1'b1;
      repeat (4) step();
      ifb.Cen[0] = 1'b0;
      prev = 4'((n - 1) % 16);
      cur  = 4'(n % 16);
      for (int d = 1; d <= 4; d++) begin
        mask = 4'((1 << d) - 1);
        eq   = (prev & ~mask) | (cur & mask);
        et   = ((d == 1) || ((n % (1 << (d - 1))) == 0)) ? 4'(1 << (d - 1)) : 4'b0000;
        ex(1'b1, d, eq, ~eq, et, "ripple_count");
      end
      repeat (4) step();
    end

    for (int w = 0; w < 20; w++) begin
      if (sb.size() == 0) break;
      step();
    end
    draining = 1'b1;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
